// File: rtl/font_rom_arbiter_if.sv
// Bundle between the overlay generators, the shared font ROM and the arbiter.
// slave = arbiter side, master = requester/ROM side.
interface font_rom_arbiter_if #(
  parameter int NREQ = 4
);
  logic                en;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   req_bank;
  logic [4*NREQ-1:0]   req_char;
  logic [4*NREQ-1:0]   req_row;
  logic [NREQ-1:0]     gnt;
  logic [1:0]          rom_bank;
  logic [3:0]          rom_char;
  logic [3:0]          rom_row;
  logic [7:0]          rom_data;
  logic [NREQ-1:0]     rsp_valid;
  logic [7:0]          rsp_data;
  logic                busy;

  modport slave (
    input  en, req, req_bank, req_char, req_row, rom_data,
    output gnt, rom_bank, rom_char, rom_row, rsp_valid, rsp_data, busy
  );

  modport master (
    output en, req, req_bank, req_char, req_row, rom_data,
    input  gnt, rom_bank, rom_char, rom_row, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one font ROM; one accept per cycle, response
// strobed 2+ROM_LAT cycles after accept, no backpressure on the response.
module font_rom_arbiter #(
  parameter int NREQ    = 4,
  parameter int ROM_LAT = 0
) (
  input logic               clk,
  input logic               reset,
  font_rom_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int D  = 2 + ROM_LAT;

  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_found;
  logic            w_accept;
  logic [NREQ-1:0] w_gnt;

  logic [1:0]      r_rom_bank;
  logic [3:0]      r_rom_char;
  logic [3:0]      r_rom_row;

  logic [D-1:0]    r_pipe_vld;
  logic [IW-1:0]   r_pipe_idx [D];
  logic [7:0]      r_rsp_data;
  logic [NREQ-1:0] w_rsp_valid;

  // Search upward from ptr+1 so the last winner has lowest priority.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (w_found && bus.en && reset) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign w_accept = |w_gnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr      <= IW'(NREQ - 1);
      r_rom_bank <= '0;
      r_rom_char <= '0;
      r_rom_row  <= '0;
      r_pipe_vld <= '0;
      r_rsp_data <= '0;
      for (int i = 0; i < D; i++) begin
        r_pipe_idx[i] <= '0;
      end
    end else begin
      r_pipe_vld    <= {r_pipe_vld[D-2:0], w_accept};
      r_pipe_idx[0] <= w_gnt_idx;
      for (int i = 1; i < D; i++) begin
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
      // ROM data lines up with the stage just before the strobe.
      if (r_pipe_vld[D-2]) begin
        r_rsp_data <= bus.rom_data;
      end
      if (w_accept) begin
        r_ptr      <= w_gnt_idx;
        r_rom_bank <= bus.req_bank[{w_gnt_idx, 1'b0} +: 2];
        r_rom_char <= bus.req_char[{w_gnt_idx, 2'b00} +: 4];
        r_rom_row  <= bus.req_row[{w_gnt_idx, 2'b00} +: 4];
      end else if (!bus.en) begin
        r_rom_bank <= 2'd1;
        r_rom_char <= 4'd15;
        r_rom_row  <= 4'd0;
      end
    end
  end

  always_comb begin
    w_rsp_valid = '0;
    if (r_pipe_vld[D-1]) begin
      w_rsp_valid[r_pipe_idx[D-1]] = 1'b1;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rom_bank  = r_rom_bank;
  assign bus.rom_char  = r_rom_char;
  assign bus.rom_row   = r_rom_row;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = |r_pipe_vld;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Randomized bench for font_rom_arbiter with a round-robin reference model
// feeding a response scoreboard that an independent monitor drains.
module tb_font_rom_arbiter;
  localparam int NREQ    = 4;
  localparam int ROM_LAT = 1;
  localparam int D       = 2 + ROM_LAT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  font_rom_arbiter_if #(.NREQ(NREQ)) bus ();

  font_rom_arbiter #(.NREQ(NREQ), .ROM_LAT(ROM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] rom_fn(input logic [1:0] b, input logic [3:0] c,
                                        input logic [3:0] r);
    return {b, c, r[1:0]} ^ {r, c};
  endfunction

  generate
    if (ROM_LAT == 0) begin : g_rom0
      assign bus.rom_data = rom_fn(bus.rom_bank, bus.rom_char, bus.rom_row);
    end else begin : g_romn
      logic [7:0] q [ROM_LAT];
      always @(posedge clk) begin
        q[0] <= rom_fn(bus.rom_bank, bus.rom_char, bus.rom_row);
        for (int i = 1; i < ROM_LAT; i++) q[i] <= q[i-1];
      end
      assign bus.rom_data = q[ROM_LAT-1];
    end
  endgenerate

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } rsp_t;

  rsp_t sb[$];
  bit   armed = 1'b0;

  // Reference model: expected grant, address registers, and queued responses.
  int         m_ptr;
  logic [1:0] m_bank;
  logic [3:0] m_char;
  logic [3:0] m_row;

  initial begin
    int         acc;
    logic [3:0] exp_gnt;
    logic [1:0] b;
    logic [3:0] c;
    logic [3:0] r;
    rsp_t       e;
    forever begin
      @(negedge clk);
      #1;
      acc     = -1;
      exp_gnt = '0;
      if (reset && bus.en) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (acc < 0 && bus.req[(m_ptr + k) % NREQ]) acc = (m_ptr + k) % NREQ;
        end
      end
      if (acc >= 0) exp_gnt[acc] = 1'b1;
      if (armed) begin
        check("gnt", bus.gnt, exp_gnt);
        check("rom_bank", bus.rom_bank, m_bank);
        check("rom_char", bus.rom_char, m_char);
        check("rom_row", bus.rom_row, m_row);
      end
      if (!reset) begin
        armed  = 1'b1;
        m_ptr  = NREQ - 1;
        m_bank = '0;
        m_char = '0;
        m_row  = '0;
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      end else if (armed && acc >= 0) begin
        b      = bus.req_bank[2*acc +: 2];
        c      = bus.req_char[4*acc +: 4];
        r      = bus.req_row[4*acc +: 4];
        m_ptr  = acc;
        m_bank = b;
        m_char = c;
        m_row  = r;
        e.idx  = acc;
        e.data = rom_fn(b, c, r);
        e.due  = cyc + D;
        sb.push_back(e);
      end else if (armed && !bus.en) begin
        m_bank = 2'd1;
        m_char = 4'd15;
        m_row  = 4'd0;
      end
    end
  end

  // Monitor: runs before the model each cycle, so the queue holds only older accepts.
  initial begin
    rsp_t       e;
    logic [7:0] last_data;
    last_data = '0;
    forever begin
      @(negedge clk);
      if (armed) begin
        check("busy", {31'd0, bus.busy}, {31'd0, sb.size() > 0});
        if (bus.rsp_valid !== '0) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", {28'd0, bus.rsp_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_tag", {28'd0, bus.rsp_valid}, 32'(1 << e.idx));
            check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e.data});
            check("rsp_cycle", cyc, e.due);
            last_data = e.data;
          end
        end else begin
          check("rsp_hold", {24'd0, bus.rsp_data}, {24'd0, last_data});
          if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("rsp_missing", {28'd0, bus.rsp_valid}, 32'(1 << e.idx));
          end
        end
      end
      if (!reset) last_data = '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_slices();
    bus.req_bank = 8'($urandom);
    bus.req_char = 16'($urandom);
    bus.req_row  = 16'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    bus.en = 1'b1;
    bus.req = 4'hF;
    rand_slices();
    tick(3);
    reset = 1'b1;
    tick(1);
    bus.req = 4'h0;
    tick(2);

    // Single requester with fixed address slices
    bus.req = 4'b0100;
    bus.req_bank[5:4] = 2'd2;
    bus.req_char[11:8] = 4'd6;
    bus.req_row[11:8] = 4'd5;
    tick(1);
    bus.req = 4'h0;
    tick(4);

    // All requesters asserted
    bus.req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      rand_slices();
      tick(1);
    end
    bus.req = 4'h0;
    tick(4);

    // Wrap from ptr=2 over to the low requesters
    bus.req = 4'b0100;
    tick(1);
    bus.req = 4'b0011;
    rand_slices();
    tick(2);
    bus.req = 4'h0;
    tick(4);

    // en drops with a read in flight
    bus.req = 4'b0001;
    tick(1);
    bus.en = 1'b0;
    bus.req = 4'hF;
    tick(4);
    bus.en = 1'b1;
    bus.req = 4'h0;
    tick(2);

    // Reset one cycle after an accept
    bus.req = 4'b0010;
    rand_slices();
    tick(1);
    bus.req = 4'h0;
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(5);

    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 49) != 0);
      bus.en = ($urandom_range(0, 7) != 0);
      bus.req = 4'($urandom);
      rand_slices();
      tick(1);
    end

    reset = 1'b1;
    bus.en = 1'b1;
    bus.req = 4'h0;
    tick(10);
    check("drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
